// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command engine: FSM states, header bit layout
// and the header byte 0 decoder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_WR_DATA,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_PUSH
  } state_e;

  localparam int OP_BIT    = 0;
  localparam int LEN_LSB   = 1;
  localparam int INC_BIT   = 7;
  localparam int LEN_MAX_W = 6;

  typedef struct packed {
    logic                 op;
    logic [LEN_MAX_W-1:0] len_m1;
    logic                 inc;
  } header_t;

  // len_m1 is returned at its widest; callers keep the low LEN_W bits.
  function automatic header_t header_decode(input logic [7:0] b);
    header_t h;
    h.op     = b[OP_BIT];
    h.len_m1 = b[LEN_LSB +: LEN_MAX_W];
    h.inc    = b[INC_BIT];
    return h;
  endfunction

endpackage

// File: rtl/uart_cmd_engine_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and
// raises a combinational expire on the cycle the count reaches TIMEOUT_CYC.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      // This enabled cycle is the TIMEOUT_CYC-th one since the last clear.
      assign expire = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/uart_cmd_engine.sv
// Command engine: parses a two-byte header from the RX FIFO, then runs a
// read or write memory burst; read data is returned through the TX FIFO.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int LEN_W       = 4,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rx_rd,
  input  logic              tx_full,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_done,
  output logic              err_timeout
);

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              inc_q, inc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lat_q, lat_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              cap_q, cap_d;
  logic              tx_wr_q, tx_wr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              cmd_done_q, cmd_done_d;

  header_t hdr;
  logic    unused_hdr;
  logic    in_rx_wait;
  logic    to_expire;
  logic    last_beat;
  logic [7:0] rd_byte;

  assign hdr        = header_decode(rx_data);
  assign unused_hdr = ^hdr;
  assign in_rx_wait = (state_q == ST_HDR1) || (state_q == ST_WR_DATA);
  assign rx_rd      = !rx_empty && ((state_q == ST_IDLE) || in_rx_wait);
  assign last_beat  = (cnt_q == len_q);

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (rx_rd || !in_rx_wait),
    .en    (in_rx_wait && rx_empty),
    .expire(to_expire)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    inc_d       = inc_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    cap_d       = cap_q;
    tx_wr_d     = 1'b0;
    tx_data_d   = tx_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    cmd_done_d  = 1'b0;
    rd_byte     = cap_q ? rdata_q : mem_rdata;
    case (state_q)
      ST_IDLE: begin
        if (rx_rd) begin
          op_d    = hdr.op;
          len_d   = hdr.len_m1[LEN_W-1:0];
          inc_d   = hdr.inc;
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (rx_rd) begin
          addr_d  = rx_data[ADDR_W-1:0];
          cnt_d   = '0;
          state_d = op_q ? ST_RD_ISSUE : ST_WR_DATA;
        end else if (to_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (rx_rd) begin
          mem_wr_d    = 1'b1;
          mem_wdata_d = rx_data;
          mem_addr_d  = addr_q;
          addr_d      = addr_q + ADDR_W'(inc_q);
          cnt_d       = cnt_q + 1'b1;
          if (last_beat) begin
            cmd_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (to_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        if (!tx_full) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_q;
          lat_d      = '0;
          cap_d      = 1'b0;
          state_d    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == 2'(RD_LAT - 1)) begin
          state_d = ST_RD_PUSH;
        end
      end
      ST_RD_PUSH: begin
        // mem_rdata is valid on the first RD_PUSH cycle; hold it across a TX stall.
        if (!cap_q) begin
          rdata_d = mem_rdata;
          cap_d   = 1'b1;
        end
        if (!tx_full) begin
          tx_wr_d   = 1'b1;
          tx_data_d = rd_byte;
          cap_d     = 1'b0;
          addr_d    = addr_q + ADDR_W'(inc_q);
          cnt_d     = cnt_q + 1'b1;
          if (last_beat) begin
            cmd_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 1'b0;
      len_q       <= '0;
      inc_q       <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      rdata_q     <= '0;
      cap_q       <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      cmd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      inc_q       <= inc_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      rdata_q     <= rdata_d;
      cap_q       <= cap_d;
      tx_wr_q     <= tx_wr_d;
      tx_data_q   <= tx_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      cmd_done_q  <= cmd_done_d;
    end
  end

  assign tx_wr       = tx_wr_q;
  assign tx_data     = tx_data_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_rd      = mem_rd_q;
  assign cmd_done    = cmd_done_q;
  assign err_timeout = to_expire;
  assign busy        = (state_q != ST_IDLE);

endmodule
